// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared types and defaults for the FIFO read-side drain
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int SKID_DEPTH    = 2;
  localparam int DEF_WIDTH     = 16;
  localparam int DEF_BURST_LEN = 8;
  localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/fifo_rd_drain_if.sv
// rtl/fifo_rd_drain_if.sv - FIFO pop port plus outgoing valid/ready stream
interface fifo_rd_drain_if
  import fifo_rd_pkg::*;
#(
  parameter int width = DEF_WIDTH
) ();

  logic             FIFO_empty;
  logic [width-1:0] data_out;
  logic             rd_en;
  logic [width-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    input  FIFO_empty,
    input  data_out,
    input  out_ready,
    output rd_en,
    output out_data,
    output out_valid,
    output out_last
  );

  modport slave (
    output FIFO_empty,
    output data_out,
    output out_ready,
    input  rd_en,
    input  out_data,
    input  out_valid,
    input  out_last
  );

endinterface

// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - two-entry single-clock skid buffer absorbing FIFO read latency
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int width = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] head_data,
  output logic             head_valid,
  output logic [1:0]       occupancy
);

  localparam logic [1:0] FULL = 2'(SKID_DEPTH);

  logic [width-1:0] mem [SKID_DEPTH];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_pop  = pop & (count != 2'd0);
  assign do_push = push & ((count != FULL) | do_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_data  = mem[rd_ptr];
  assign head_valid = (count != 2'd0);
  assign occupancy  = count;

endmodule

// File: rtl/fifo_rd_drain.sv
// rtl/fifo_rd_drain.sv - read-domain FIFO consumer with burst framing; FIFO_RD_STATS_EN adds rd_count
module fifo_rd_drain
  import fifo_rd_pkg::*;
#(
  parameter int width     = DEF_WIDTH,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic            clk_r,
  input  logic            reset,
  input  logic            enable,
  fifo_rd_drain_if.master bus,
  output logic            busy
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [CNT_W-1:0] rd_count
`endif
);

  localparam int              BW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0]   LAST_CNT = BW'(BURST_LEN - 1);
  localparam logic [1:0]      CREDITS  = 2'(SKID_DEPTH);

  if (BURST_LEN < 1 || CNT_W < 1) begin : g_bad_params
    $error("fifo_rd_drain: BURST_LEN and CNT_W must be at least 1");
  end

  state_t           state;
  logic             inflight;
  logic [BW-1:0]    burst_cnt;
  logic [width-1:0] head_data;
  logic             head_valid;
  logic [1:0]       occupancy;
  logic [1:0]       pending;
  logic             xfer;
  logic             credit_ok;

  assign xfer    = head_valid & bus.out_ready;
  assign pending = occupancy + {1'b0, inflight};

  // A word leaving this cycle frees its slot in time for a read issued now,
  // which is what keeps one word per clock with ready held high.
  assign credit_ok = (pending - {1'b0, xfer}) < CREDITS;
  assign bus.rd_en = (state == RUN) & enable & ~bus.FIFO_empty & credit_ok;

  fifo_rd_skid #(
    .width(width)
  ) u_skid (
    .clk       (clk_r),
    .reset     (reset),
    .push      (inflight),
    .push_data (bus.data_out),
    .pop       (xfer),
    .head_data (head_data),
    .head_valid(head_valid),
    .occupancy (occupancy)
  );

  assign bus.out_data  = head_data;
  assign bus.out_valid = head_valid;
  assign bus.out_last  = head_valid & (burst_cnt == LAST_CNT);

  always_ff @(posedge clk_r) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      inflight  <= 1'b0;
      burst_cnt <= '0;
    end else begin
      inflight <= bus.rd_en;

      if (xfer) begin
        if (burst_cnt == LAST_CNT) burst_cnt <= '0;
        else                       burst_cnt <= burst_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (enable) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!enable) begin
            if (pending != 2'd0) begin
              state <= DRAIN;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (enable) begin
            state <= RUN;
          end else if (pending == 2'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge clk_r) begin
    if (!reset)    rd_count <= '0;
    else if (xfer) rd_count <= rd_count + 1'b1;
  end
`endif

endmodule
